// File: rtl/jk_seq_pkg.sv
// Shared mode codes and Gray/JK helper functions for the jk_seq_gen sequencer.
package jk_seq_pkg;

  localparam int unsigned MAX_W = 16;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_GRAY = 2'b11;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB; zero-extended inputs decode correctly at any width.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Per-bit excitation: returns {j,k} that moves a JK cell from q to n.
  function automatic logic [1:0] jk_encode(input logic q, input logic n, input logic exc_mode);
    if (exc_mode) begin
      return {q ^ n, q ^ n};
    end
    return {~q & n, q & ~n};
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit combinational J/K encoder from current state q to target state n.
module jk_excite
  import jk_seq_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned EXC_MODE = 0
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] n,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  localparam logic EXC_BIT = (EXC_MODE != 0);

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign {j[i], k[i]} = jk_encode(q[i], n[i], EXC_BIT);
  end

endmodule

// File: rtl/jk_ff.sv
// JK flip-flop cell with synchronous active-low reset.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_gen.sv
// Programmable W-bit sequence register built from jk_ff cells driven by J/K excitation.
module jk_seq_gen
  import jk_seq_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned EXC_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic [W-1:0] j_o,
  output logic [W-1:0] k_o,
  output logic         wrap
);

  localparam logic [W-1:0] ONES     = {W{1'b1}};
  localparam logic [W-1:0] GRAY_TOP = W'(1) << (W - 1);

  logic [W-1:0] n;
  logic [W-1:0] gray_next;
  logic [W-1:0] j_raw;
  logic [W-1:0] k_raw;
  logic         step;
  logic         wrap_d;

  // Binary successor is truncated to W bits before re-encoding to Gray.
  assign gray_next = W'(bin2gray(MAX_W'(W'(gray2bin(MAX_W'(q)) + MAX_W'(1)))));
  assign step      = !load && en && (mode != MODE_HOLD);

  // Next target state, load over mode-driven step.
  always_comb begin
    n = q;
    if (load) begin
      n = load_val;
    end else if (en) begin
      case (mode)
        MODE_UP:   n = q + W'(1);
        MODE_DOWN: n = q - W'(1);
        MODE_GRAY: n = gray_next;
        default:   n = q;
      endcase
    end
  end

  // Wrap is seen as a q/N pair at the sequence seam, never on a load.
  always_comb begin
    wrap_d = 1'b0;
    if (step) begin
      case (mode)
        MODE_UP:   wrap_d = (q == ONES)     && (n == '0);
        MODE_DOWN: wrap_d = (q == '0)       && (n == ONES);
        MODE_GRAY: wrap_d = (q == GRAY_TOP) && (n == '0);
        default:   wrap_d = 1'b0;
      endcase
    end
  end

  jk_excite #(
    .W        (W),
    .EXC_MODE (EXC_MODE)
  ) u_excite (
    .q (q),
    .n (n),
    .j (j_raw),
    .k (k_raw)
  );

  assign j_o = rst ? j_raw : '0;
  assign k_o = rst ? k_raw : '0;

  for (genvar i = 0; i < int'(W); i++) begin : g_cell
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j_o[i]),
      .k   (k_o[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_jk_seq_gen.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_jk_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q0, q1, j0, k0, j1, k1;
  logic       wrap0, wrap1;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  int m_q = 0;
  bit m_wrap = 1'b0;
  int gseq [16];

  always #5 clk = ~clk;

  jk_seq_gen #(.W(4), .EXC_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q0), .j_o(j0), .k_o(k0), .wrap(wrap0)
  );

  jk_seq_gen #(.W(4), .EXC_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q1), .j_o(j1), .k_o(k1), .wrap(wrap1)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray successor found by position in the Gray code list.
  function automatic int gray_succ(input int g);
    for (int i = 0; i < 16; i++) begin
      if (gseq[i] == g) return gseq[(i + 1) % 16];
    end
    return 0;
  endfunction

  function automatic int model_next();
    if (load) return int'(load_val);
    if (!en) return m_q;
    case (mode)
      2'd1: return (m_q + 1) % 16;
      2'd2: return (m_q + 15) % 16;
      2'd3: return gray_succ(m_q);
      default: return m_q;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) gseq[i] = i ^ (i / 2);
  end

  // Reference model advances on each posedge from the inputs held that cycle.
  always @(posedge clk) begin
    int nx;
    if (!rst) begin
      m_q = 0;
      m_wrap = 1'b0;
    end else begin
      nx = model_next();
      m_wrap = !load && en && (mode != 2'd0) &&
               ((mode == 2'd2) ? (nx == 15) : (nx == 0));
      m_q = nx;
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    int nx;
    logic [3:0] qv, nv;
    if (started) begin
      nx = model_next();
      qv = 4'(m_q);
      nv = 4'(nx);
      chk("q_exc0", q0, qv);
      chk("q_exc1", q1, qv);
      chk("wrap_exc0", {3'b0, wrap0}, {3'b0, m_wrap});
      chk("wrap_exc1", {3'b0, wrap1}, {3'b0, m_wrap});
      if (!rst) begin
        chk("j_rst0", j0, 4'h0); chk("k_rst0", k0, 4'h0);
        chk("j_rst1", j1, 4'h0); chk("k_rst1", k1, 4'h0);
      end else begin
        chk("j_exc0", j0, ~qv & nv);
        chk("k_exc0", k0, qv & ~nv);
        chk("j_exc1", j1, qv ^ nv);
        chk("k_exc1", k1, qv ^ nv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  logic [3:0] gexp [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    rst = 1'b0; en = 1'b1; mode = 2'b01; load = 1'b0; load_val = 4'h0;
    step();
    started = 1'b1;
    step();
    chk("reset_q", q0, 4'h0);
    chk("reset_wrap", {3'b0, wrap0}, 4'h0);
    chk("reset_j", j0, 4'h0);
    chk("reset_k", k1, 4'h0);

    // Up wrap
    rst = 1'b1;
    do_load(4'hE);
    chk("up_load", q0, 4'hE);
    en = 1'b1; mode = 2'b01;
    step(); chk("up_f", q0, 4'hF); chk("up_f_wrap", {3'b0, wrap0}, 4'h0);
    step(); chk("up_0", q0, 4'h0); chk("up_0_wrap", {3'b0, wrap0}, 4'h1);
    step(); chk("up_1", q1, 4'h1); chk("up_1_wrap", {3'b0, wrap1}, 4'h0);

    // Down wrap
    do_load(4'h1);
    mode = 2'b10;
    step(); chk("dn_0", q0, 4'h0); chk("dn_0_wrap", {3'b0, wrap0}, 4'h0);
    step(); chk("dn_f", q0, 4'hF); chk("dn_f_wrap", {3'b0, wrap0}, 4'h1);
    step(); chk("dn_e", q1, 4'hE); chk("dn_e_wrap", {3'b0, wrap1}, 4'h0);

    // Gray sequence
    do_load(4'h0);
    mode = 2'b11;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("gray_seq", q0, gexp[i]);
      chk("gray_wrap", {3'b0, wrap0}, (i == 15) ? 4'h1 : 4'h0);
    end

    // Excitation of a 5 -> A load
    do_load(4'h5);
    load = 1'b1; load_val = 4'hA;
    #1;
    chk("exc0_j", j0, 4'hA); chk("exc0_k", k0, 4'h5);
    chk("exc1_j", j1, 4'hF); chk("exc1_k", k1, 4'hF);
    step(); load = 1'b0;
    chk("exc0_q", q0, 4'hA); chk("exc1_q", q1, 4'hA);

    // Load priority, then reset mid-count
    load = 1'b1; load_val = 4'h7; en = 1'b1; mode = 2'b01;
    step(); load = 1'b0;
    chk("prio_q", q0, 4'h7); chk("prio_wrap", {3'b0, wrap0}, 4'h0);
    step(); chk("prio_8", q0, 4'h8);
    rst = 1'b0;
    step(); chk("mid_rst_q", q0, 4'h0); chk("mid_rst_wrap", {3'b0, wrap0}, 4'h0);
    rst = 1'b1;
    step(); chk("resume_1", q0, 4'h1);
    step(); chk("resume_2", q1, 4'h2);

    // Random stimulus, checked every cycle by the compare process
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 29) != 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
